// File: rtl/fifo_csr_master.sv
// CSR master that flushes a FIFO: it sets CTRL, polls STATUS until the FIFO is empty, then clears CTRL.
// Define CSR_MASTER_TIMEOUT_EN to bound polling at POLL_LIMIT STATUS reads.
module fifo_csr_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int POLL_LIMIT = 16
) (
    input  logic                  csr_clk,
    input  logic                  csr_resetn,
    input  logic                  cmd_start,
    output logic                  cmd_busy,
    output logic                  cmd_done,
    output logic                  cmd_empty,
    output logic                  cmd_error,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [2:0] {
        IDLE, SET_AW, SET_B, POLL_AR, POLL_R, CLR_AW, CLR_B, DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = '0;
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(1);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;

    state_t state;
    logic   aw_ok;
    logic   w_ok;
    logic   unused_rdata;

    // A channel counts as finished once its valid is low or is being accepted this cycle.
    assign aw_ok        = !m_awvalid || m_awready;
    assign w_ok         = !m_wvalid || m_wready;
    assign m_wlast      = m_wvalid;
    assign unused_rdata = ^m_rdata[DATA_WIDTH-1:1];

`ifdef CSR_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_LIMIT + 1);
    logic [CNT_W-1:0] poll_cnt;
    logic [CNT_W-1:0] poll_next;
    logic             poll_expired;

    assign poll_next    = poll_cnt + CNT_W'(1);
    assign poll_expired = (poll_next >= CNT_W'(POLL_LIMIT));
`else
    logic unused_poll_limit;
    assign unused_poll_limit = (POLL_LIMIT != 0);
`endif

    always_ff @(posedge csr_clk or negedge csr_resetn) begin
        if (!csr_resetn) begin
            state     <= IDLE;
            cmd_busy  <= 1'b0;
            cmd_done  <= 1'b0;
            cmd_empty <= 1'b0;
            cmd_error <= 1'b0;
            m_awaddr  <= '0;
            m_awvalid <= 1'b0;
            m_wdata   <= '0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_araddr  <= '0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
`ifdef CSR_MASTER_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            cmd_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        state     <= SET_AW;
                        cmd_busy  <= 1'b1;
                        cmd_error <= 1'b0;
                        cmd_empty <= 1'b0;
                        m_awaddr  <= CTRL_ADDR;
                        m_wdata   <= DATA_WIDTH'(1);
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
`ifdef CSR_MASTER_TIMEOUT_EN
                        poll_cnt  <= '0;
`endif
                    end
                end
                // Address and data channels complete independently, in either order.
                SET_AW, CLR_AW: begin
                    if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                    if (m_wvalid && m_wready) m_wvalid <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_bready <= 1'b1;
                        state    <= (state == SET_AW) ? SET_B : CLR_B;
                    end
                end
                SET_B: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        if (m_bresp != RESP_OKAY) begin
                            cmd_error <= 1'b1;
                            cmd_done  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            m_araddr  <= STATUS_ADDR;
                            m_arvalid <= 1'b1;
                            state     <= POLL_AR;
                        end
                    end
                end
                POLL_AR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        cmd_empty <= m_rdata[0];
`ifdef CSR_MASTER_TIMEOUT_EN
                        poll_cnt  <= poll_next;
                        if (!m_rdata[0] && poll_expired) cmd_error <= 1'b1;
                        if (m_rdata[0] || poll_expired) begin
`else
                        if (m_rdata[0]) begin
`endif
                            m_awaddr  <= CTRL_ADDR;
                            m_wdata   <= '0;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                            state     <= CLR_AW;
                        end else begin
                            m_arvalid <= 1'b1;
                            state     <= POLL_AR;
                        end
                    end
                end
                CLR_B: begin
                    if (m_bvalid) begin
                        m_bready <= 1'b0;
                        if (m_bresp != RESP_OKAY) cmd_error <= 1'b1;
                        cmd_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    cmd_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_csr_master.sv
// Table-driven bench for fifo_csr_master with a behavioural CSR slave answering on the falling edge.
module tb_fifo_csr_master;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          csr_clk = 1'b0;
    logic          csr_resetn = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_busy, cmd_done, cmd_empty, cmd_error;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata;
    logic          m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
    logic          m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic          m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]    m_bresp = 2'b00;
    logic [DW-1:0] m_rdata = '0;

    fifo_csr_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POLL_LIMIT(4)) dut (
        .csr_clk(csr_clk), .csr_resetn(csr_resetn), .cmd_start(cmd_start),
        .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_empty(cmd_empty), .cmd_error(cmd_error),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 csr_clk = ~csr_clk;

    typedef struct {
        int             aw_delay;
        int             w_delay;
        logic [1:0]     set_bresp;
        logic [1:0]     clr_bresp;
        int             n_status;
        logic [3:0][7:0] status;
        bit             extra_start;
        int             exp_reads;
        int             exp_writes;
        int             exp_error;
        int             exp_empty;
        int             exp_latency;
        int             exp_aw_hold;
        int             exp_w_hold;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Slave configuration, written only by the stimulus process.
    bit              slave_clear = 1'b1;
    int              cfg_aw_delay = 0;
    int              cfg_w_delay = 0;
    logic [1:0]      cfg_set_bresp = 2'b00;
    logic [1:0]      cfg_clr_bresp = 2'b00;
    int              cfg_n_status = 1;
    logic [3:0][7:0] cfg_status = '0;

    // Slave state and transaction log, written only by the slave process.
    int            aw_wait = 0, w_wait = 0, aw_high = 0, w_high = 0;
    int            aw_hs = 0, w_hs = 0, b_total = 0, rcount = 0, wcount = 0;
    int            aw_hold0 = 0, w_hold0 = 0, stab_err = 0, proto_err = 0;
    bit            r_pending = 1'b0;
    logic [AW-1:0] aw_first = '0;
    logic [DW-1:0] w_first = '0;
    logic [DW-1:0] wlog [0:7];
    int            sidx;

    always @(negedge csr_clk) begin
        if (slave_clear) begin
            m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
            m_bresp = 2'b00; m_rdata = '0;
            aw_wait = 0; w_wait = 0; aw_high = 0; w_high = 0; aw_hs = 0; w_hs = 0; b_total = 0;
            rcount = 0; wcount = 0; aw_hold0 = 0; w_hold0 = 0; stab_err = 0; proto_err = 0;
            r_pending = 1'b0;
        end else begin
            // Readies/valids driven last half cycle were accepted on the rising edge just passed.
            if (m_awready) begin
                if (aw_hs == 0) aw_hold0 = aw_high;
                aw_hs++; aw_high = 0; aw_wait = 0; m_awready = 1'b0;
            end
            if (m_wready) begin
                if (w_hs == 0) w_hold0 = w_high;
                if (wcount < 8) wlog[wcount] = w_first;
                wcount++; w_hs++; w_high = 0; w_wait = 0; m_wready = 1'b0;
            end
            if (m_arready) begin m_arready = 1'b0; r_pending = 1'b1; end
            if (m_rvalid) begin m_rvalid = 1'b0; rcount++; end
            if (m_bvalid) begin m_bvalid = 1'b0; b_total++; end

            if (m_awvalid) begin
                if (aw_high == 0) aw_first = m_awaddr;
                else if (m_awaddr != aw_first) stab_err++;
                if (m_awaddr != '0) proto_err++;
                aw_high++;
                if (aw_wait >= cfg_aw_delay) m_awready = 1'b1; else aw_wait++;
            end
            if (m_wvalid) begin
                if (w_high == 0) w_first = m_wdata;
                else if (m_wdata != w_first) stab_err++;
                w_high++;
                if (w_wait >= cfg_w_delay) m_wready = 1'b1; else w_wait++;
            end
            if (m_wlast != m_wvalid) proto_err++;
            if (m_arvalid) begin
                if (m_araddr != AW'(1)) proto_err++;
                m_arready = 1'b1;
            end
            if (r_pending && m_rready) begin
                sidx = (rcount < cfg_n_status) ? rcount : cfg_n_status - 1;
                m_rdata = cfg_status[sidx[1:0]];
                m_rvalid = 1'b1;
                r_pending = 1'b0;
            end
            if (m_bready && aw_hs > b_total && w_hs > b_total) begin
                m_bresp = (b_total == 0) ? cfg_set_bresp : cfg_clr_bresp;
                m_bvalid = 1'b1;
            end
        end
    end

    function automatic logic [63:0] all_outputs();
        return 64'({cmd_busy, cmd_done, cmd_empty, cmd_error, m_awaddr, m_awvalid, m_wdata,
                    m_wvalid, m_wlast, m_bready, m_araddr, m_arvalid, m_rready});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearSlave();
        slave_clear = 1'b1;
        @(negedge csr_clk);
        @(negedge csr_clk);
        slave_clear = 1'b0;
    endtask

    // Runs one flush with the given slave behaviour and checks the outcome against the vector.
    task automatic applyStimulus(input vec_t v, input string tag);
        int  cycles;
        bit  done_seen;
        cfg_aw_delay  = v.aw_delay;
        cfg_w_delay   = v.w_delay;
        cfg_set_bresp = v.set_bresp;
        cfg_clr_bresp = v.clr_bresp;
        cfg_n_status  = v.n_status;
        cfg_status    = v.status;
        clearSlave();
        cmd_start = 1'b1;
        cycles    = 1;
        done_seen = 1'b0;
        while (!done_seen && cycles < 400) begin
            @(negedge csr_clk);
            cycles++;
            cmd_start = v.extra_start && (cycles == 3);
            if (cycles == 2) checkOutput({tag, "_busy"}, 64'(cmd_busy), 64'd1);
            if (cmd_done) done_seen = 1'b1;
        end
        cmd_start = 1'b0;
        checkOutput({tag, "_done_seen"}, 64'(done_seen), 64'd1);
        checkOutput({tag, "_latency"}, 64'(cycles), 64'(v.exp_latency));
        @(negedge csr_clk);
        checkOutput({tag, "_done_pulse_busy"}, 64'({cmd_done, cmd_busy}), 64'd0);
        checkOutput({tag, "_reads"}, 64'(rcount), 64'(v.exp_reads));
        checkOutput({tag, "_writes"}, 64'(wcount), 64'(v.exp_writes));
        if (v.exp_writes >= 1 && wcount >= 1) checkOutput({tag, "_wdata_set"}, 64'(wlog[0]), 64'd1);
        if (v.exp_writes >= 2 && wcount >= 2) checkOutput({tag, "_wdata_clr"}, 64'(wlog[1]), 64'd0);
        checkOutput({tag, "_error"}, 64'(cmd_error), 64'(v.exp_error));
        checkOutput({tag, "_empty"}, 64'(cmd_empty), 64'(v.exp_empty));
        checkOutput({tag, "_aw_hold"}, 64'(aw_hold0), 64'(v.exp_aw_hold));
        checkOutput({tag, "_w_hold"}, 64'(w_hold0), 64'(v.exp_w_hold));
        checkOutput({tag, "_stable"}, 64'(stab_err), 64'd0);
        checkOutput({tag, "_protocol"}, 64'(proto_err), 64'd0);
    endtask

    initial begin
        vec_t vecs [8];
        vec_t tv;
        bit   found;
        // Fields: aw_delay, w_delay, set_bresp, clr_bresp, n_status, status (read0 in low byte), extra_start,
        //         exp_reads, exp_writes, exp_error, exp_empty, exp_latency (start cycle = 1), exp_aw_hold, exp_w_hold
        vecs[0] = '{0, 0, 2'b00, 2'b00, 1, 32'h0000_0001, 1'b0, 1, 2, 0, 1,  8, 1, 1};
        vecs[1] = '{0, 0, 2'b00, 2'b00, 3, 32'h0001_0002, 1'b1, 3, 2, 0, 1, 12, 1, 1};
        vecs[2] = '{2, 0, 2'b00, 2'b00, 1, 32'h0000_0001, 1'b0, 1, 2, 0, 1, 12, 3, 1};
        vecs[3] = '{0, 0, 2'b10, 2'b00, 1, 32'h0000_0001, 1'b0, 0, 1, 1, 0,  4, 1, 1};
        vecs[4] = '{0, 0, 2'b00, 2'b11, 1, 32'h0000_0001, 1'b0, 1, 2, 1, 1,  8, 1, 1};
        vecs[5] = '{0, 1, 2'b00, 2'b00, 1, 32'h0000_0003, 1'b0, 1, 2, 0, 1, 10, 1, 2};
        vecs[6] = '{0, 0, 2'b00, 2'b00, 2, 32'h0000_0100, 1'b0, 2, 2, 0, 1, 10, 1, 1};
        vecs[7] = '{0, 0, 2'b00, 2'b00, 4, 32'h0100_0000, 1'b0, 4, 2, 0, 1, 14, 1, 1};

        repeat (3) @(negedge csr_clk);
        checkOutput("reset_outputs", all_outputs(), 64'd0);
        csr_resetn = 1'b1;
        @(negedge csr_clk);
        checkOutput("idle_busy", 64'(cmd_busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

`ifdef CSR_MASTER_TIMEOUT_EN
        tv = '{0, 0, 2'b00, 2'b00, 1, 32'h0000_0000, 1'b0, 4, 2, 1, 0, 14, 1, 1};
        applyStimulus(tv, "timeout");
`endif

        // Reset while waiting on read data, then a full sequence afterwards.
        tv = '{0, 0, 2'b00, 2'b00, 1, 32'h0000_0000, 1'b0, 0, 0, 0, 0, 0, 0, 0};
        cfg_status   = tv.status;
        cfg_n_status = tv.n_status;
        clearSlave();
        cmd_start = 1'b1;
        @(negedge csr_clk);
        cmd_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge csr_clk);
            if (m_rready) found = 1'b1;
        end
        checkOutput("reach_poll_r", 64'(found), 64'd1);
        csr_resetn  = 1'b0;
        slave_clear = 1'b1;
        #1;
        checkOutput("reset_mid_outputs", all_outputs(), 64'd0);
        repeat (2) @(negedge csr_clk);
        csr_resetn = 1'b1;
        @(negedge csr_clk);
        checkOutput("post_reset_idle", all_outputs(), 64'd0);
        applyStimulus(vecs[0], "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
